// File: rtl/mux7_rr_arbiter_if.sv
// rtl/mux7_rr_arbiter_if.sv - request/data/grant bundle between seven requesters and the shared mux arbiter
//   req      [6:0] request per requester (driven by requester side)
//   data_in  [6:0] mux data inputs, bit i belongs to requester i
//   grant    [6:0] registered one-hot grant, zero when no grant is active
//   sel      [2:0] registered mux select, 0..6
//   busy           high while the arbiter is not idle
//   data_out       registered data_in[sel] while a grant is active, else 0
interface mux7_rr_arbiter_if;
  logic [6:0] req;
  logic [6:0] data_in;
  logic [6:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       data_out;

  modport master (
    output req,
    output data_in,
    input  grant,
    input  sel,
    input  busy,
    input  data_out
  );

  modport slave (
    input  req,
    input  data_in,
    output grant,
    output sel,
    output busy,
    output data_out
  );
endinterface

// File: rtl/mux7_rr_arbiter.sv
// rtl/mux7_rr_arbiter.sv - round-robin arbiter with hold limit and turnaround gap over a shared 7:1 bit mux
//   clock   system clock, rising edge
//   resetn  synchronous active-low reset
//   bus     mux7_rr_arbiter_if.slave: req/data_in in, grant/sel/busy/data_out out
module mux7_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               resetn,
  mux7_rr_arbiter_if.slave   bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  logic [1:0]    r_state;
  logic [6:0]    r_grant;
  logic [2:0]    r_sel;
  logic [2:0]    r_last;
  logic [HW-1:0] r_hold;
  logic          r_dout;

  logic [2:0]    w_win;
  logic          w_found;
  logic [3:0]    w_idx;
  logic          w_release;

  // Search starts just after the last holder and wraps 6->0, so the previous
  // holder is considered last.
  always_comb begin
    w_win   = 3'd0;
    w_found = 1'b0;
    w_idx   = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      w_idx = {1'b0, r_last} + 4'(k);
      if (w_idx >= 4'd7) begin
        w_idx = w_idx - 4'd7;
      end
      if (!w_found && bus.req[w_idx[2:0]]) begin
        w_win   = w_idx[2:0];
        w_found = 1'b1;
      end
    end
  end

  // r_sel is always 0..6, so the index is in range.
  assign w_release = !bus.req[r_sel] || (r_hold == HW'(MAX_HOLD));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= 7'd0;
      r_sel   <= 3'd0;
      r_last  <= 3'd6;
      r_hold  <= '0;
      r_dout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          // GAP sees r_last already updated by the release edge.
          if (w_found) begin
            r_state <= ST_ACTIVE;
            r_grant <= 7'(1) << w_win;
            r_sel   <= w_win;
            r_hold  <= HW'(1);
            r_dout  <= bus.data_in[w_win];
          end else begin
            r_state <= ST_IDLE;
            r_grant <= 7'd0;
            r_dout  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (w_release) begin
            r_state <= ST_GAP;
            r_grant <= 7'd0;
            r_last  <= r_sel;
            r_dout  <= 1'b0;
          end else begin
            r_hold  <= HW'(r_hold + 1'b1);
            r_dout  <= bus.data_in[r_sel];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 7'd0;
          r_dout  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.sel      = r_sel;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.data_out = r_dout;

endmodule
